stream_out_seq: RTL
===================

// Module: stream_out_seq
// PURPOSE
//  Parametrised output-stream sequencer for the result path of the accelerator core.
//  - Sits between the compute core and the outbound AXI-Stream-style port.
//  - On a compute-finished pulse, issues read strobes/addresses to the result buffer.
//  - Emits a framed dst_valid/dst_last stream of (cfg_len+1)*(cfg_pkts+1) words as cfg_pkts+1 packets.
//  - dst_ready acts as a global stall enable for the whole block.
//  - Adds over the previous generation: runtime length, multi-packet runs, one-deep start queue,
//    zero-bubble back-to-back runs, busy/done status.
// PARAMETERS
//  AW            8   result-buffer address width; also width of cfg_len
//  PW            4   width of cfg_pkts (max 2^PW packets per run)
//  LAST_PER_PKT  1   1: dst_last on final word of every packet; 0: only on final word of run
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  get_fin    in   1      1-cycle pulse: compute finished, results ready
//  cfg_len    in   AW     words per packet minus 1
//  cfg_pkts   in   PW     packets per run minus 1
//  dst_ready  in   1      downstream ready; global enable
//  dst_valid  out  1      output word valid (aligned with buffer read data)
//  dst_last   out  1      packet/run boundary marker
//  stream_v   out  1      result-buffer read enable
//  stream_a   out  AW     result-buffer read address
//  busy       out  1      run in progress or words still in flight
//  done       out  1      1-cycle pulse at final word of a run
// BEHAVIOUR
//  - Reset: state IDLE, pending=0, all counters 0; dst_valid, dst_last, stream_v, done, busy = 0;
//    stream_a = 0. rst mid-run aborts immediately; no partial dst_last is emitted.
//  - pending bit:
//    - Set by get_fin in any state, regardless of dst_ready.
//    - Cleared when consumed by a run start.
//    - get_fin while already pending is dropped (one-deep queue).
//    - get_fin on the same cycle as a consume re-sets pending.
//  - FSM IDLE/RUN; transitions only on edges with dst_ready=1:
//    - IDLE -> RUN when pending | get_fin. Latch cfg_len/cfg_pkts; word=0, pkt=0, addr=0.
//    - RUN: each enabled edge advances word.
//      - At word==len_q: word->0, pkt++.
//      - At word==len_q & pkt==pkts_q (final issue): if pending|get_fin, restart RUN with fresh cfg
//        (zero bubble, addr->0); else -> IDLE.
//  - Combinational outputs:
//    - stream_v = (state==RUN) & dst_ready.
//    - stream_a = addr. addr increments across packets and wraps modulo 2^AW.
//  - Registered outputs, updated only when dst_ready=1 (otherwise hold):
//    - dst_valid <= stream_v.
//    - dst_last <= stream_v & word==len_q & (LAST_PER_PKT | pkt==pkts_q).
//  - Latency: one enabled cycle from stream_v to the matching dst_valid (buffer read latency 1).
//  - done: registered, 1 clk pulse on the edge that makes the final dst_valid of a run visible;
//    never repeated while stalled.
//  - busy = (state!=IDLE) | pending | dst_valid.
//  - cfg_len=0 -> 1-word packets, dst_last on every word (LAST_PER_PKT=1).
// STRUCTURE
//  - Shared package stream_pkg:
//    - typedef enum logic {S_IDLE, S_RUN} seq_state_t.
//    - localparam default widths.
//  - Sub-module stream_cnt #(W): counter with enable, sync load-to-zero, terminal compare input.
//    Instantiated twice (word, pkt).
//  - addr is a plain AW-bit register in this block.
// TESTING
//  1. len=3, pkts=0, ready=1, get_fin@t0 -> stream_a 0..3 over t1..t4;
//     dst_valid t2..t5; dst_last t5 only; done t5.
//  2. len=1, pkts=2, LAST_PER_PKT=1 -> 6 words, addr 0..5, dst_last on words 1,3,5;
//     with LAST_PER_PKT=0 -> only word 5.
//  3. ready low 3 cycles mid-run (len=7) -> stream_v=0, outputs and counters frozen;
//     resume with no lost/duplicate address; done single pulse.
//  4. get_fin again during run (len=2) -> second run starts on the edge after final issue,
//     addr 0 with no idle cycle; third get_fin while pending -> dropped.
//  5. AW=4, len=15, pkts=1 -> addr wraps 15->0 at packet 2; 32 words, two dst_last.
//  6. rst asserted at word 2 of len=5 run -> next cycle all outputs 0, IDLE;
//     no done; new get_fin starts clean at addr 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and default widths for the result-path output stream sequencer.
package stream_pkg;

   typedef enum logic {S_IDLE, S_RUN} seq_state_t;

   localparam int unsigned AW_DEF = 8;
   localparam int unsigned PW_DEF = 4;

endpackage

// File: rtl/stream_cnt.sv
// Up-counter with enable and synchronous clear; flags when the count equals a terminal value.
module stream_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] term_i,
   output logic         at_term_c
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_term_c = (cnt_q == term_i);

endmodule

// File: rtl/stream_out_seq.sv
// Output-stream sequencer: turns compute-finished pulses into framed multi-packet result
// streams, reading the result buffer one cycle ahead of dst_valid. dst_ready stalls everything.
module stream_out_seq
   import stream_pkg::*;
#(
   parameter int unsigned AW           = AW_DEF,
   parameter int unsigned PW           = PW_DEF,
   parameter bit          LAST_PER_PKT = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          get_fin,
   input  logic [AW-1:0] cfg_len,
   input  logic [PW-1:0] cfg_pkts,
   input  logic          dst_ready,
   output logic          dst_valid,
   output logic          dst_last,
   output logic          stream_v,
   output logic [AW-1:0] stream_a,
   output logic          busy,
   output logic          done
);

   seq_state_t    state_q, state_d;
   logic          pending_q, pending_d;
   logic [AW-1:0] len_q, len_d;
   logic [PW-1:0] pkts_q, pkts_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          dst_valid_q, dst_valid_d;
   logic          dst_last_q, dst_last_d;
   logic          done_q, done_d;

   logic          start;
   logic          req;
   logic          word_end;
   logic          pkt_end;

   assign req      = pending_q | get_fin;
   assign stream_v = (state_q == S_RUN) & dst_ready;
   assign stream_a = addr_q;

   stream_cnt #(.W(AW)) u_word_cnt (
      .clk       (clk),
      .rst       (rst),
      .en_i      (stream_v),
      .clr_i     (start | (stream_v & word_end)),
      .term_i    (len_q),
      .at_term_c (word_end)
   );

   stream_cnt #(.W(PW)) u_pkt_cnt (
      .clk       (clk),
      .rst       (rst),
      .en_i      (stream_v & word_end),
      .clr_i     (start | (stream_v & word_end & pkt_end)),
      .term_i    (pkts_q),
      .at_term_c (pkt_end)
   );

   // Next state; a queued request at the final issue restarts RUN with no idle bubble.
   always_comb begin
      state_d     = state_q;
      start       = 1'b0;
      len_d       = len_q;
      pkts_d      = pkts_q;
      addr_d      = addr_q;
      dst_valid_d = dst_valid_q;
      dst_last_d  = dst_last_q;
      done_d      = stream_v & word_end & pkt_end;

      case (state_q)
         S_IDLE: begin
            if (dst_ready & req) begin
               state_d = S_RUN;
               start   = 1'b1;
            end
         end
         S_RUN: begin
            if (dst_ready & word_end & pkt_end) begin
               if (req) begin
                  start = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         len_d  = cfg_len;
         pkts_d = cfg_pkts;
         addr_d = '0;
      end else if (stream_v) begin
         addr_d = addr_q + AW'(1);
      end

      // Consuming the queue while a new pulse arrives keeps one request queued.
      pending_d = start ? (pending_q & get_fin) : req;

      if (dst_ready) begin
         dst_valid_d = stream_v;
         dst_last_d  = stream_v & word_end & (LAST_PER_PKT | pkt_end);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pending_q   <= 1'b0;
         len_q       <= '0;
         pkts_q      <= '0;
         addr_q      <= '0;
         dst_valid_q <= 1'b0;
         dst_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         len_q       <= len_d;
         pkts_q      <= pkts_d;
         addr_q      <= addr_d;
         dst_valid_q <= dst_valid_d;
         dst_last_q  <= dst_last_d;
         done_q      <= done_d;
      end
   end

   assign dst_valid = dst_valid_q;
   assign dst_last  = dst_last_q;
   assign done      = done_q;
   assign busy      = (state_q != S_IDLE) | pending_q | dst_valid_q;

endmodule
